// File: rtl/scomp2_signmag_serial.sv
// scomp2_signmag_serial
// Bit-serial two's-complement to sign-magnitude converter.
// A (W+1)-bit two's-complement word is accepted on an in_valid/in_ready
// handshake. It is then walked LSB-first, one bit per clock. Bits are copied
// until the first one; for negative words every later bit is inverted. The
// result is presented as sign, W-bit magnitude and an overflow flag on an
// out_valid/out_ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input word valid
//   in_ready   block can accept a word (state == IDLE, combinational)
//   in_data    (W+1)-bit two's-complement word, bit W is the sign
//   out_valid  result valid (registered)
//   out_ready  downstream accepts result
//   out_sign   sign of the captured word (registered)
//   out_mag    W-bit magnitude (registered)
//   out_ovf    magnitude equals 2^W, i.e. input was -2^W (registered)
//   busy       high in SHIFT or DONE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a word, in_ready high
// SHIFT | converting one bit per clock, W+1 clocks
// DONE  | result held on the outputs until out_ready

module scomp2_signmag_serial #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sign,
    output logic [W-1:0] out_mag,
    output logic         out_ovf,
    output logic         busy
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [W:0]    sr;
    logic [W:0]    acc;
    logic [CW-1:0] cnt;
    logic          sign;
    logic          seen_one;

    logic          bit_in;
    logic          res_bit;
    logic [W:0]    acc_next;

    // Copy bits up to and including the first one; invert afterwards when negative.
    assign bit_in   = sr[0];
    assign res_bit  = (sign & seen_one) ? ~bit_in : bit_in;
    assign acc_next = {res_bit, acc[W:1]};

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            acc       <= '0;
            cnt       <= '0;
            sign      <= 1'b0;
            seen_one  <= 1'b0;
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_mag   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr       <= in_data;
                        sign     <= in_data[W];
                        seen_one <= 1'b0;
                        cnt      <= '0;
                        acc      <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc      <= acc_next;
                    sr       <= {1'b0, sr[W:1]};
                    seen_one <= seen_one | bit_in;
                    cnt      <= cnt + 1'b1;
                    if (cnt == CW'(W)) begin
                        // Last bit: the sign position lands in acc[W], which is
                        // set only for -2^W.
                        out_mag   <= acc_next[W-1:0];
                        out_ovf   <= acc_next[W];
                        out_sign  <= sign;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scomp2_signmag_serial.sv
// Testbench for scomp2_signmag_serial (W = 8).
// Directed steps followed by a randomized stream, all checked against a
// sign/absolute-value reference computed with integer arithmetic.

module tb_scomp2_signmag_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W:0]   in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_sign;
    logic [W-1:0] out_mag;
    logic         out_ovf;
    logic         busy;

    int checks = 0;
    int errors = 0;

    scomp2_signmag_serial #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: {sign, ovf, mag} from the signed value and its absolute value.
    function automatic logic [W+1:0] ref_conv(input logic [W:0] d);
        int v;
        int a;
        logic [W:0] a_bits;
        v = d[W] ? int'(d) - (1 << (W + 1)) : int'(d);
        a = (v < 0) ? -v : v;
        a_bits = a[W:0];
        return {(v < 0), (a == (1 << W)), a_bits[W-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = (W+1)'($urandom);
    endtask

    // Waits for out_valid after an accept edge, checking latency and result.
    task automatic convert(input logic [W:0] d, input string tag);
        int lat;
        logic [W+1:0] e;
        send(d);
        lat = 0;
        while (!out_valid && lat < 40) begin
            chk({tag, "_ready_low"}, 32'(in_ready), 0);
            chk({tag, "_busy"}, 32'(busy), 1);
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_latency"}, 32'(lat), W + 1);
        chk({tag, "_ready_done"}, 32'(in_ready), 0);
        e = ref_conv(d);
        chk({tag, "_result"}, 32'({out_sign, out_ovf, out_mag}), 32'(e));
    endtask

    task automatic handshake_done(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_valid_drop"}, 32'(out_valid), 0);
        chk({tag, "_ready_back"}, 32'(in_ready), 1);
        chk({tag, "_busy_drop"}, 32'(busy), 0);
    endtask

    initial begin
        logic [W+1:0] held;
        logic [W+1:0] e;
        logic [W+1:0] expq[$];
        logic [W:0]   word;
        logic         holding;
        logic         fire_in;
        logic         fire_out;
        int           sent;
        int           got;
        int           cyc;
        int           last_acc;

        // Reset state
        #1;
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_outs", 32'({out_valid, out_sign, out_ovf, out_mag, busy}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // +5, then -5, -1, +255 with out_ready held high
        out_ready = 1'b1;
        convert(9'h005, "p5");
        chk("p5_const", 32'({out_sign, out_ovf, out_mag}), 32'({1'b0, 1'b0, 8'h05}));
        handshake_done("p5");
        convert(9'h1FB, "m5");
        chk("m5_const", 32'({out_sign, out_ovf, out_mag}), 32'({1'b1, 1'b0, 8'h05}));
        handshake_done("m5");
        convert(9'h1FF, "m1");
        chk("m1_const", 32'({out_sign, out_ovf, out_mag}), 32'({1'b1, 1'b0, 8'h01}));
        handshake_done("m1");
        convert(9'h0FF, "p255");
        chk("p255_const", 32'({out_sign, out_ovf, out_mag}), 32'({1'b0, 1'b0, 8'hFF}));
        handshake_done("p255");

        // -256 overflow case and zero
        convert(9'h100, "m256");
        chk("m256_const", 32'({out_sign, out_ovf, out_mag}), 32'({1'b1, 1'b1, 8'h00}));
        handshake_done("m256");
        convert(9'h000, "zero");
        chk("zero_const", 32'({out_sign, out_ovf, out_mag}), 0);
        handshake_done("zero");

        // -127 held in DONE with out_ready low while in_valid/in_data toggle
        out_ready = 1'b0;
        convert(9'h181, "m127");
        held = {out_sign, out_ovf, out_mag};
        chk("m127_const", 32'(held), 32'({1'b1, 1'b0, 8'h7F}));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'(i % 2 == 0);
            in_data  = (W+1)'($urandom);
            #1;
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_ready", 32'(in_ready), 0);
            chk("hold_result", 32'({out_sign, out_ovf, out_mag}), {1'b1, 1'b0, 8'h7F});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        handshake_done("hold");
        chk("retain_result", 32'({out_sign, out_ovf, out_mag}), {1'b1, 1'b0, 8'h7F});

        // Reset at the 4th SHIFT edge aborts the conversion
        send(9'h1FB);
        repeat (3) @(posedge clk);
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(in_ready), 1);
        chk("abort_outs", 32'({out_valid, out_sign, out_ovf, out_mag, busy}), 0);
        @(negedge clk);
        rst = 1'b0;
        convert(9'h003, "p3");
        chk("p3_const", 32'({out_sign, out_ovf, out_mag}), 32'({1'b0, 1'b0, 8'h03}));
        handshake_done("p3");

        // Random stream with random out_ready stalls
        sent = 0;
        got = 0;
        cyc = 0;
        last_acc = 0;
        holding = 1'b0;
        word = '0;
        while ((sent < 200 || expq.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!holding && sent < 200 && $urandom_range(0, 3) != 0) begin
                holding = 1'b1;
                case ($urandom_range(0, 9))
                    0: word = 9'h100;
                    1: word = 9'h000;
                    2: word = 9'h1FF;
                    default: word = (W+1)'($urandom);
                endcase
            end
            in_valid  = holding;
            in_data   = holding ? word : (W+1)'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                if (expq.size() == 0) begin
                    chk("rand_spurious", 32'(fire_out), 0);
                end else begin
                    e = expq.pop_front();
                    chk("rand_result", 32'({out_sign, out_ovf, out_mag}), 32'(e));
                    got++;
                end
            end
            if (fire_in) begin
                expq.push_back(ref_conv(word));
                if (sent > 0)
                    chk("rand_spacing", 32'((cyc - last_acc) >= W + 3), 1);
                last_acc = cyc;
                sent++;
                holding = 1'b0;
            end
            @(posedge clk);
        end
        in_valid = 1'b0;
        chk("rand_sent", 32'(sent), 200);
        chk("rand_got", 32'(got), 200);
        chk("rand_queue_empty", 32'(expq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scomp2_signmag_serial.md
# scomp2_signmag_serial

Bit-serial converter from two's-complement to sign-magnitude. This is the inverse path of the team's binary-to-two's-complement block. It accepts one (W+1)-bit two's-complement word through a valid/ready handshake. It then walks the word LSB-first, one bit per clock, using the copy-until-first-one-then-invert rule, and presents sign, W-bit magnitude and an overflow flag through a second valid/ready handshake. It sits between arithmetic datapaths that produce signed results and display/BCD stages that need unsigned magnitudes.

## Interface
- W, 8, magnitude width. Input word is W+1 bits. Legal range W >= 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word; combinational, equals (state == IDLE).
- in_data  in  W+1  two's-complement word; bit W is the sign.
- out_valid  out  1  result valid; registered.
- out_ready  in  1  downstream accepts result.
- out_sign  out  1  sign of the captured word; registered.
- out_mag  out  W  magnitude, low W bits; registered.
- out_ovf  out  1  magnitude equals 2^W (input was -2^W); registered.
- busy  out  1  high in SHIFT or DONE.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid at a clock edge:
    - capture in_data into shift register sr;
    - capture sign = in_data[W];
    - clear seen_one, cnt and mag accumulator;
    - go to SHIFT.
  - SHIFT: each edge processes bit b = sr[0]:
    - result bit r = sign & seen_one ? ~b : b;
    - seen_one <= seen_one | b;
    - r shifts into the MSB of a (W+1)-bit accumulator acc, which shifts right;
    - sr shifts right;
    - cnt increments.
    - At the edge where cnt == W (the (W+1)th bit): load out_mag = final acc[W-1:0], out_ovf = final acc[W], out_sign = sign, out_valid <= 1, then go to DONE.
  - DONE: hold all outputs stable. On out_valid & out_ready at an edge: out_valid <= 0, go to IDLE. out_sign, out_mag and out_ovf retain their last values.
- Positive inputs (sign=0) copy bits unchanged, so out_mag = in_data[W-1:0] and out_ovf = 0.
- -2^W (sign=1, all other bits 0) yields out_ovf=1, out_mag=0, out_sign=1. This is the only ovf case.
- Zero yields sign 0, mag 0. There is no negative zero.
- in_valid while in_ready=0 is ignored. The word is not latched, and the upstream must hold it.
- in_data is sampled only at the accept edge. Later changes to in_data do not affect the conversion in progress.
- No overlap: a new word is accepted no earlier than the edge after the DONE→IDLE transition.

## Timing
- Reset (async assert, regardless of state):
  - state IDLE, so in_ready=1;
  - out_valid=0, out_sign=0, out_mag=0, out_ovf=0, busy=0;
  - sr, acc, cnt and seen_one cleared.
- Reset mid-SHIFT or mid-DONE aborts the conversion with no output pulse.
- Latency: out_valid rises W+1 clock edges after the accept edge (9 for W=8).
- Throughput: W+3 cycles per word minimum, with out_ready held high (accept, W+1 shifts, IDLE edge).
- out_ready may be held high in advance; the handshake completes on the first DONE edge.
- out_ready during IDLE or SHIFT has no effect.
- in_ready is combinational from state only, with no path from in_valid or out_ready.

## Test plan
- W=8, accept 0x005 (+5) with out_ready=1 → out_valid rises exactly 9 edges after accept; sign=0, mag=0x05, ovf=0; in_ready low during SHIFT/DONE.
- Accept 0x1FB (-5), then 0x1FF (-1), then 0x0FF (+255) → results (1,0x05,0), (1,0x01,0), (0,0xFF,0).
- Accept 0x100 (-256) → sign=1, mag=0x00, ovf=1. Accept 0x000 → sign=0, mag=0x00, ovf=0.
- Accept 0x181 (-127) with out_ready=0 for 6 cycles after out_valid → result (1,0x7F,0) held stable. Toggle in_valid/in_data during the hold → ignored, in_ready=0. Raise out_ready → out_valid drops next edge, in_ready=1.
- Accept 0x1FB, assert rst at the 4th SHIFT edge → all outputs 0 and in_ready=1 immediately. Release rst, accept 0x003 → result (0,0x03,0) with standard 9-edge latency.
- Back-to-back random stream of 200 words with random out_ready stalls → every result matches the sign/abs reference; no word is lost or duplicated; each word takes at least W+3 cycles.
